// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
// Holds the state and player-status encodings plus LFSR and BCD helpers.
package reaction_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_REACT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PL_PENDING = 2'd0,
        PL_DONE    = 2'd1,
        PL_CHEAT   = 2'd2,
        PL_TIMEOUT = 2'd3
    } pstat_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as zero-based bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_ms_counter.sv
// Millisecond prescaler feeding a DIGITS-wide BCD up-counter.
// Synchronous clear wins over enable; the count holds once every digit is 9.
module bcd_ms_counter #(
    parameter int CLK_HZ = 100_000_000,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                en_i,
    output logic                tick_o,
    output logic [4*DIGITS-1:0] count_o
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]       PRE_LAST  = PW'(DIV - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [PW-1:0]       pre_q, pre_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                carry;

    assign tick_o  = en_i && (pre_q == PRE_LAST);
    assign count_o = cnt_q;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        carry = 1'b1;
        if (clr_i) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (en_i) begin
            pre_d = tick_o ? '0 : pre_q + 1'b1;
            if (tick_o && (cnt_q != ALL_NINES)) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (carry) begin
                        if (cnt_q[4*i +: 4] == 4'd9) begin
                            cnt_d[4*i +: 4] = 4'd0;
                        end else begin
                            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_reaction_timer.sv
// Multi-player reaction timer: random wait, stimulus light, per-player BCD
// reaction capture, tie-aware winner vector and best-time-since-reset.
module multi_reaction_timer
    import reaction_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int PLAYERS        = 2,
    parameter int DIGITS         = 4,
    parameter int MIN_WAIT_MS    = 1000,
    parameter int WAIT_SPAN_LOG2 = 11,
    parameter int TIMEOUT_MS     = 1000
) (
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    input  logic                          start,
    input  logic                          clear,
    input  logic [PLAYERS-1:0]            react,
    output logic [1:0]                    state,
    output logic                          stim,
    output logic [PLAYERS*4*DIGITS-1:0]   time_bcd,
    output logic [2*PLAYERS-1:0]          status,
    output logic [PLAYERS-1:0]            winner,
    output logic [4*DIGITS-1:0]           best_bcd,
    output logic                          best_valid
);
    localparam int TW = 4 * DIGITS;
    localparam int WW = $clog2(MIN_WAIT_MS + 2**WAIT_SPAN_LOG2) + 1;
    localparam logic [31:0]   TIMEOUT_BCD32 = to_bcd(TIMEOUT_MS);
    localparam logic [TW-1:0] TIMEOUT_BCD   = TIMEOUT_BCD32[TW-1:0];

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q;
    logic [WW-1:0]      wait_q, wait_d;
    logic               start_q, start_edge_q, clear_q, clear_edge_q;
    logic [PLAYERS-1:0] react_q, react_edge_q;
    logic [TW-1:0]      time_q [PLAYERS];
    logic [TW-1:0]      time_d [PLAYERS];
    pstat_e             status_q [PLAYERS];
    pstat_e             status_d [PLAYERS];
    logic [PLAYERS-1:0] winner_q, win_d;
    logic [TW-1:0]      best_q, min_t;
    logic               best_valid_q, stim_q, min_found;
    logic               all_cheat, any_pending, enter_done;
    logic               cnt_clr, cnt_en, tick;
    logic [TW-1:0]      count;

    // The counter restarts on every entry into a timed state.
    assign cnt_clr    = (state_d != state_q) && (state_d == ST_WAIT || state_d == ST_REACT);
    assign cnt_en     = (state_q == ST_WAIT) || (state_q == ST_REACT);
    assign enter_done = (state_q != ST_DONE) && (state_d == ST_DONE);

    bcd_ms_counter #(.CLK_HZ(CLK_HZ), .DIGITS(DIGITS)) u_ms (
        .clk     (CLK100MHZ),
        .rst_n   (CPU_RESETN),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .tick_o  (tick),
        .count_o (count)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        time_d      = time_q;
        status_d    = status_q;
        all_cheat   = 1'b1;
        any_pending = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_q) begin
                    state_d = ST_WAIT;
                    wait_d  = WW'(MIN_WAIT_MS) + WW'(lfsr_q[WAIT_SPAN_LOG2-1:0]);
                    for (int p = 0; p < PLAYERS; p++) begin
                        time_d[p]   = '0;
                        status_d[p] = PL_PENDING;
                    end
                end
            end
            ST_WAIT: begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (react_edge_q[p] && status_q[p] == PL_PENDING) begin
                        status_d[p] = PL_CHEAT;
                        time_d[p]   = '0;
                    end
                    if (status_d[p] != PL_CHEAT) all_cheat = 1'b0;
                end
                if (all_cheat)           state_d = ST_DONE;
                else if (wait_q == '0)   state_d = ST_REACT;
                else if (tick)           wait_d  = wait_q - 1'b1;
            end
            ST_REACT: begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (react_edge_q[p] && status_q[p] == PL_PENDING) begin
                        status_d[p] = PL_DONE;
                        time_d[p]   = count;
                    end
                    if (status_d[p] == PL_PENDING) any_pending = 1'b1;
                end
                if (!any_pending) begin
                    state_d = ST_DONE;
                end else if (count == TIMEOUT_BCD) begin
                    // Presses landing on the timeout cycle were already recorded above.
                    state_d = ST_DONE;
                    for (int p = 0; p < PLAYERS; p++) begin
                        if (status_d[p] == PL_PENDING) begin
                            status_d[p] = PL_TIMEOUT;
                            time_d[p]   = TIMEOUT_BCD;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (clear_edge_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // BCD digit order matches numeric order, so plain compares find the minimum.
    always_comb begin
        min_found = 1'b0;
        min_t     = '1;
        win_d     = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (status_d[p] == PL_DONE && (!min_found || time_d[p] < min_t)) begin
                min_found = 1'b1;
                min_t     = time_d[p];
            end
        end
        for (int p = 0; p < PLAYERS; p++) begin
            if (status_d[p] == PL_DONE && time_d[p] == min_t) win_d[p] = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_SEED;
            wait_q       <= '0;
            start_q      <= 1'b0;
            start_edge_q <= 1'b0;
            clear_q      <= 1'b0;
            clear_edge_q <= 1'b0;
            react_q      <= '0;
            react_edge_q <= '0;
            winner_q     <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            stim_q       <= 1'b0;
            for (int p = 0; p < PLAYERS; p++) begin
                time_q[p]   <= '0;
                status_q[p] <= PL_PENDING;
            end
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_next(lfsr_q);
            wait_q       <= wait_d;
            start_q      <= start;
            start_edge_q <= start & ~start_q;
            clear_q      <= clear;
            clear_edge_q <= clear & ~clear_q;
            react_q      <= react;
            react_edge_q <= react & ~react_q;
            stim_q       <= (state_d == ST_REACT);
            time_q       <= time_d;
            status_q     <= status_d;
            if (enter_done) begin
                winner_q <= win_d;
                if (min_found && (!best_valid_q || min_t < best_q)) begin
                    best_q       <= min_t;
                    best_valid_q <= 1'b1;
                end
            end else if (state_q == ST_IDLE && state_d == ST_WAIT) begin
                winner_q <= '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_pack
            assign time_bcd[gi*TW +: TW] = time_q[gi];
            assign status[2*gi +: 2]     = status_q[gi];
        end
    endgenerate

    assign state      = state_q;
    assign stim       = stim_q;
    assign winner     = winner_q;
    assign best_bcd   = best_q;
    assign best_valid = best_valid_q;

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Scoreboard bench: each round pushes its hand-computed result, and a
// monitor compares the outputs on every entry into DONE.
`timescale 1ns/1ps
module tb_multi_reaction_timer;
    // A press level is registered, then edge-registered, so at 1 kHz the
    // captured count is one ms later than the cycle the level rises.
    localparam int LAT = 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_REACT = 2'd2, S_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  react = 2'b00;
    logic [1:0]  state;
    logic        stim;
    logic [31:0] time_bcd;
    logic [3:0]  status;
    logic [1:0]  winner;
    logic [15:0] best_bcd;
    logic        best_valid;

    typedef struct {
        string       name;
        logic [15:0] t0;
        logic [15:0] t1;
        logic [3:0]  st;
        logic [1:0]  win;
        logic [15:0] best;
        logic        bv;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    multi_reaction_timer #(
        .CLK_HZ(1000), .PLAYERS(2), .DIGITS(4),
        .MIN_WAIT_MS(4), .WAIT_SPAN_LOG2(2), .TIMEOUT_MS(50)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .start      (start),
        .clear      (clear),
        .react      (react),
        .state      (state),
        .stim       (stim),
        .time_bcd   (time_bcd),
        .status     (status),
        .winner     (winner),
        .best_bcd   (best_bcd),
        .best_valid (best_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string what);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(what, 32'(state), 32'(s));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  32'(state),      32'd0);
        check({tag, "_stim"},   32'(stim),       32'd0);
        check({tag, "_time"},   time_bcd,        32'd0);
        check({tag, "_status"}, 32'(status),     32'd0);
        check({tag, "_winner"}, 32'(winner),     32'd0);
        check({tag, "_best"},   32'(best_bcd),   32'd0);
        check({tag, "_bvalid"}, 32'(best_valid), 32'd0);
    endtask

    // ms0/ms1: REACT-relative ms value to be captured; -1 means no press.
    task automatic round(input string name, input logic [1:0] cheat, input int ms0, input int ms1,
                         input logic [15:0] t0, input logic [15:0] t1, input logic [3:0] st,
                         input logic [1:0] win, input logic [15:0] best, input logic bv);
        exp_t e;
        e.name = name; e.t0 = t0; e.t1 = t1; e.st = st; e.win = win; e.best = best; e.bv = bv;
        exp_q.push_back(e);
        start = 1'b1;
        wait_state(S_WAIT, 10, {name, "_enter_wait"});
        start = 1'b0;
        react = cheat;
        if (cheat == 2'b11) begin
            wait_state(S_DONE, 20, {name, "_cheat_done"});
        end else begin
            wait_state(S_REACT, 40, {name, "_enter_react"});
            for (int c = 0; c < 200 && state == S_REACT; c++) begin
                if (c == ms0 - LAT) react[0] = 1'b1;
                if (c == ms1 - LAT) react[1] = 1'b1;
                @(negedge clk);
            end
            wait_state(S_DONE, 5, {name, "_enter_done"});
        end
        @(negedge clk);
        react = 2'b00;
        clear = 1'b1;
        wait_state(S_IDLE, 10, {name, "_back_idle"});
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin : monitor
        logic [1:0] prev;
        exp_t e;
        prev = S_IDLE;
        forever begin
            @(negedge clk);
            if (state == S_DONE && prev != S_DONE) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE entry, required none pending");
                end else begin
                    e = exp_q.pop_front();
                    $display("round %s: time0=%h time1=%h status=%b winner=%b best=%h valid=%b",
                             e.name, time_bcd[15:0], time_bcd[31:16], status, winner, best_bcd, best_valid);
                    check({e.name, "_time0"},  32'(time_bcd[15:0]),  32'(e.t0));
                    check({e.name, "_time1"},  32'(time_bcd[31:16]), 32'(e.t1));
                    check({e.name, "_status"}, 32'(status),          32'(e.st));
                    check({e.name, "_winner"}, 32'(winner),          32'(e.win));
                    check({e.name, "_best"},   32'(best_bcd),        32'(e.best));
                    check({e.name, "_bvalid"}, 32'(best_valid),      32'(e.bv));
                    check({e.name, "_stim"},   32'(stim),            32'd0);
                end
            end
            if (state == S_REACT && prev != S_REACT) check("stim_in_react", 32'(stim), 32'd1);
            prev = state;
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        round("basic",     2'b00,  7, 12, 16'h0007, 16'h0012, 4'b0101, 2'b01, 16'h0007, 1'b1);
        round("p1_cheat",  2'b10,  9, -1, 16'h0009, 16'h0000, 4'b1001, 2'b01, 16'h0007, 1'b1);
        round("both_cheat",2'b11, -1, -1, 16'h0000, 16'h0000, 4'b1010, 2'b00, 16'h0007, 1'b1);
        round("tie",       2'b00,  5,  5, 16'h0005, 16'h0005, 4'b0101, 2'b11, 16'h0005, 1'b1);
        round("timeout",   2'b00, -1, -1, 16'h0050, 16'h0050, 4'b1111, 2'b00, 16'h0005, 1'b1);

        start = 1'b1;
        wait_state(S_WAIT, 10, "rst_round_wait");
        start = 1'b0;
        wait_state(S_REACT, 40, "rst_round_react");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        round("after_rst", 2'b00,  7, 10, 16'h0007, 16'h0010, 4'b0101, 2'b01, 16'h0007, 1'b1);
        round("slower",    2'b00, 20, 25, 16'h0020, 16'h0025, 4'b0101, 2'b01, 16'h0007, 1'b1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_reaction_timer.md
# multi_reaction_timer

Parametrised multi-player reaction timer: a start press arms a pseudo-random wait, then the stimulus output lights and a millisecond BCD counter runs until each player presses, cheats or times out. Per-player reaction times, per-player status, a tie-aware winner vector and a best-time-since-reset register are held for display. Sits between the board button/switch inputs and the existing 7-segment multiplexer and BCD-to-segment decoders; display formatting stays outside the block.

## Interface
- CLK_HZ, 100_000_000 — clock frequency; one ms tick every CLK_HZ/1000 cycles (must divide exactly).
- PLAYERS, 2 — number of reaction inputs, 1..8.
- DIGITS, 4 — BCD digits per time value.
- MIN_WAIT_MS, 1000 — minimum random wait.
- WAIT_SPAN_LOG2, 11 — random extra wait 0..2^WAIT_SPAN_LOG2-1 ms, ≤16.
- TIMEOUT_MS, 1000 — round timeout, < 10^DIGITS.
- CLK100MHZ  in  1  clock, all logic on rising edge.
- CPU_RESETN  in  1  asynchronous active-low reset.
- start  in  1  synchronised level; rising edge starts a round.
- clear  in  1  synchronised level; rising edge returns DONE to IDLE.
- react  in  PLAYERS  synchronised levels; rising edge of bit p = player p press.
- state  out  2  IDLE=0, WAIT=1, REACT=2, DONE=3.
- stim  out  1  stimulus light, high only in REACT.
- time_bcd  out  PLAYERS*4*DIGITS  captured time per player, player p at [p*4*DIGITS +: 4*DIGITS].
- status  out  2*PLAYERS  per player: PENDING=0, DONE=1, CHEAT=2, TIMEOUT=3.
- winner  out  PLAYERS  one-hot or multi-hot (ties) in DONE.
- best_bcd  out  4*DIGITS  lowest valid time since reset.
- best_valid  out  1  best_bcd holds a real time.

## Operation
- All inputs edge-detected internally (one registered copy each); held levels act once.
- IDLE: start edge → WAIT; sample wait = MIN_WAIT_MS + lfsr[WAIT_SPAN_LOG2-1:0]; clear time_bcd, status, winner.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset, steps every cycle in all states.
- WAIT: ms counter counts; react edge by player p → status[p]=CHEAT, time_bcd[p]=0. Wait expiry → REACT. All players CHEAT → DONE immediately.
- REACT: counter restarted at 0; react edge by PENDING player p captures current count into time_bcd[p], status=DONE. Presses by non-PENDING players ignored. Leave when no PENDING player remains, or count reaches TIMEOUT_MS: all PENDING → TIMEOUT, time = TIMEOUT_MS.
- DONE: winner[p]=1 for every DONE player whose time equals the minimum DONE time; winner all 0 if none. If minimum < best_bcd or !best_valid, update best and set best_valid. clear edge → IDLE; start ignored.
- BCD compare done on concatenated digits (BCD order = numeric order).
- start, clear ignored outside IDLE/DONE respectively; clear also ignored in IDLE.

## Timing
- Reset: state IDLE, stim 0, time_bcd 0, status all PENDING, winner 0, best_bcd 0, best_valid 0, LFSR seed, counters 0.
- Input edge visible one cycle after the level rises (edge register); state changes on the following clock edge.
- Prescaler cleared on WAIT and REACT entry; first ms tick CLK_HZ/1000 cycles after entry.
- stim registered: high exactly the cycles state==REACT.
- Press on a cycle where tick also increments: capture the pre-increment value.
- Simultaneous presses: all captured with the same value; tie yields multiple winner bits.
- Last press and timeout same cycle: press wins (status DONE).
- winner, best updated on the single cycle entering DONE; stable until next start.
- CPU_RESETN assertion mid-round: immediate return to reset values, including best.

## Structure
- Package reaction_pkg: state enum, player-status enum, LFSR seed and tap constants.
- Sub-module bcd_ms_counter: prescaler plus DIGITS-digit BCD counter, sync clear, enable, count output, saturates at all 9s; one instance.

## Test plan
- CLK_HZ=1000, MIN_WAIT_MS=4, WAIT_SPAN_LOG2=2, TIMEOUT_MS=50, PLAYERS=2 for all: reset → all outputs at reset values, state 0.
- start, player0 press 7 ms into REACT, player1 at 12 → times 0007/0012, status DONE/DONE, winner 01, best 0007, best_valid 1.
- Player1 presses during WAIT, player0 at 9 → status[1]=CHEAT, winner 01; both cheat → DONE straight from WAIT, winner 00.
- Both press same cycle at 5 ms → both times 0005, winner 11.
- No presses → after 50 ms both TIMEOUT, times 0050, winner 00, best unchanged.
- CPU_RESETN low mid-REACT → outputs to reset values; second round 20 ms after a 7 ms round leaves best 0007.
